// File: rtl/gelato_cache_pkg.sv
// gelato_cache_pkg: shared FSM type and default geometry for the gelato L1 instruction cache
package gelato_cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MISS_REQ,
        ST_REFILL,
        ST_RESPOND
    } icache_state_e;

    localparam int DEF_LINE_COUNT = 64;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DATA_WIDTH     = 32;
    localparam int BYTE_BITS      = 2;
    localparam int DEF_WORD_BITS  = $clog2(DEF_LINE_WORDS);
    localparam int DEF_INDEX_BITS = $clog2(DEF_LINE_COUNT);

    // Tag width left over once byte, word and index fields are taken from the address
    function automatic int tag_bits(input int addr_w, input int line_count, input int line_words);
        return addr_w - BYTE_BITS - $clog2(line_words) - $clog2(line_count);
    endfunction

endpackage

// File: rtl/gelato_l1_icache_array.sv
// gelato_l1_icache_array: valid bits, tags and data words of the direct-mapped instruction cache
module gelato_l1_icache_array
    import gelato_cache_pkg::*;
#(
    parameter int LINE_COUNT = DEF_LINE_COUNT,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int TAG_W      = tag_bits(32, DEF_LINE_COUNT, DEF_LINE_WORDS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [$clog2(LINE_COUNT)-1:0] rd_index,
    input  logic [$clog2(LINE_WORDS)-1:0] rd_word,
    output logic                          rd_valid,
    output logic [TAG_W-1:0]              rd_tag,
    output logic [DATA_WIDTH-1:0]         rd_data,
    input  logic                          wr_en,
    input  logic [$clog2(LINE_COUNT)-1:0] wr_index,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_word,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          tag_we,
    input  logic [TAG_W-1:0]              wr_tag,
    input  logic                          set_valid
);

    logic [LINE_COUNT-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]      tag_mem  [LINE_COUNT];
    logic [DATA_WIDTH-1:0] data_mem [LINE_COUNT*LINE_WORDS];

    // Flush wins over a same-cycle line fill so a flushed refill never becomes visible
    always_comb begin
        valid_d = valid_q;
        if (set_valid) valid_d[wr_index] = 1'b1;
        if (flush) valid_d = '0;
    end

    // Only the valid bits carry reset; tags and data are qualified by them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    // Single word-write port for refill beats plus the tag write on the final beat
    always_ff @(posedge clk) begin
        if (wr_en)  data_mem[{wr_index, wr_word}] <= wr_data;
        if (tag_we) tag_mem[wr_index] <= wr_tag;
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[{rd_index, rd_word}];

endmodule

// File: rtl/gelato_l1_icache.sv
// gelato_l1_icache: direct-mapped blocking L1 instruction cache with line refill from the next level
module gelato_l1_icache
    import gelato_cache_pkg::*;
#(
    parameter int LINE_COUNT = DEF_LINE_COUNT,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rdy,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    input  logic                  flush,
    output logic                  mem_req_valid,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_req_ready,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data
);

    localparam int WW  = $clog2(LINE_WORDS);
    localparam int IW  = $clog2(LINE_COUNT);
    localparam int OFF = WW + BYTE_BITS;
    localparam int TW  = tag_bits(ADDR_WIDTH, LINE_COUNT, LINE_WORDS);

    icache_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] mem_req_addr_q, mem_req_addr_d;
    logic [WW-1:0]         beat_q, beat_d;
    logic                  idle_q, idle_d;
    logic                  mem_req_valid_q, mem_req_valid_d;
    logic                  flushed_q, flushed_d;

    logic [IW-1:0]         idx;
    logic [WW-1:0]         word;
    logic [TW-1:0]         tag;
    logic                  line_valid;
    logic [TW-1:0]         line_tag;
    logic [DATA_WIDTH-1:0] line_data;
    logic                  hit, flush_en, beat_fire, last_beat, set_valid;

    assign idx  = addr_q[OFF +: IW];
    assign word = addr_q[BYTE_BITS +: WW];
    assign tag  = addr_q[ADDR_WIDTH-1 -: TW];

    assign hit       = line_valid && (line_tag == tag);
    assign flush_en  = flush && rdy;
    assign beat_fire = rdy && (state_q == ST_REFILL) && mem_resp_valid;
    assign last_beat = beat_fire && (beat_q == WW'(LINE_WORDS - 1));
    assign set_valid = last_beat && !flushed_q;

    assign req_ready     = idle_q && rdy;
    assign resp_valid    = rdy && (((state_q == ST_LOOKUP) && hit) || (state_q == ST_RESPOND));
    assign resp_data     = resp_valid ? line_data : '0;
    assign resp_addr     = addr_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;

    gelato_l1_icache_array #(
        .LINE_COUNT (LINE_COUNT),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TW)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush_en),
        .rd_index  (idx),
        .rd_word   (word),
        .rd_valid  (line_valid),
        .rd_tag    (line_tag),
        .rd_data   (line_data),
        .wr_en     (beat_fire),
        .wr_index  (idx),
        .wr_word   (beat_q),
        .wr_data   (mem_resp_data),
        .tag_we    (last_beat),
        .wr_tag    (tag),
        .set_valid (set_valid)
    );

    // Next-state logic; everything holds while rdy is low
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        beat_d          = beat_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;
        flushed_d       = flushed_q;
        if (rdy) begin
            case (state_q)
                ST_IDLE: if (req_valid && idle_q) begin
                    state_d = ST_LOOKUP;
                    addr_d  = req_addr;
                end
                ST_LOOKUP: if (hit) state_d = ST_IDLE;
                else begin
                    state_d         = ST_MISS_REQ;
                    mem_req_valid_d = 1'b1;
                    mem_req_addr_d  = {addr_q[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                    beat_d          = '0;
                    flushed_d       = 1'b0;
                end
                ST_MISS_REQ: if (mem_req_ready) begin
                    state_d         = ST_REFILL;
                    mem_req_valid_d = 1'b0;
                end
                ST_REFILL: if (mem_resp_valid) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == WW'(LINE_WORDS - 1)) state_d = ST_RESPOND;
                end
                ST_RESPOND: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
            if (flush && (state_q == ST_MISS_REQ || state_q == ST_REFILL)) flushed_d = 1'b1;
        end
        idle_d = rdy ? (state_d == ST_IDLE) : idle_q;
    end

    // FSM and registered outputs; reset abandons any refill at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            beat_q          <= '0;
            idle_q          <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            flushed_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            beat_q          <= beat_d;
            idle_q          <= idle_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            flushed_q       <= flushed_d;
        end
    end

endmodule

// File: tb/tb_gelato_l1_icache.sv
// tb_gelato_l1_icache: vector table, corner sequences and randomized fetches against a line-level model
module tb_gelato_l1_icache;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [31:0] resp_addr;
    logic        flush = 1'b0;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;

    int tests = 0;
    int fails = 0;

    logic        mv [64];
    logic [21:0] mt [64];

    typedef struct {
        logic [31:0] addr;
        int          dly;
        int          fl;
        logic        exp_hit;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [11];

    gelato_l1_icache dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rdy            (rdy),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_addr      (resp_addr),
        .flush          (flush),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h10) return 32'hA0 + {30'd0, a[3:2]};
        return {16'hC0DE, a[15:2], 2'b00};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_clear();
        foreach (mv[i]) mv[i] = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_data"}, resp_data, 0);
        check({tag, "_resp_addr"}, resp_addr, 0);
        check({tag, "_mem_req_valid"}, mem_req_valid, 0);
        check({tag, "_mem_req_addr"}, mem_req_addr, 0);
    endtask

    // Called at a negedge; returns at the negedge of the LOOKUP cycle
    task automatic start_req(input logic [31:0] a);
        int n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input int dly, input int fl,
                         input logic exp_hit, input logic [31:0] exp_data);
        logic [31:0] line;
        line = {a[31:4], 4'h0};
        start_req(a);
        check("lookup_hit", resp_valid, exp_hit);
        if (exp_hit) begin
            check("hit_data", resp_data, exp_data);
            check("hit_addr", resp_addr, a);
            check("hit_no_mem_req", mem_req_valid, 0);
            flush = (fl == 4);
        end else begin
            @(negedge clk);
            check("mem_req_valid", mem_req_valid, 1);
            check("mem_req_addr", mem_req_addr, line);
            for (int i = 0; i < dly; i++) begin
                @(negedge clk);
                check("mem_req_hold_valid", mem_req_valid, 1);
                check("mem_req_hold_addr", mem_req_addr, line);
            end
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            check("mem_req_dropped", mem_req_valid, 0);
            for (int b = 0; b < 4; b++) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = mem_word(line + 32'(4 * b));
                flush          = (fl == b);
                @(negedge clk);
            end
            mem_resp_valid = 1'b0;
            flush          = 1'b0;
            check("miss_resp_valid", resp_valid, 1);
            check("miss_resp_data", resp_data, exp_data);
            check("miss_resp_addr", resp_addr, a);
            if (fl >= 0 && fl <= 3) model_clear();
            else begin
                mv[a[9:4]] = 1'b1;
                mt[a[9:4]] = a[31:10];
            end
        end
        @(negedge clk);
        if (flush) model_clear();
        flush = 1'b0;
        check("resp_pulse_end", resp_valid, 0);
    endtask

    initial begin
        logic [31:0] a;
        int          fl;
        logic        eh;

        vecs[0]  = '{32'h100, 0, -1, 1'b0, 32'hA0};
        vecs[1]  = '{32'h108, 0, -1, 1'b1, 32'hA2};
        vecs[2]  = '{32'h500, 0, -1, 1'b0, 32'hC0DE0500};
        vecs[3]  = '{32'h100, 0, -1, 1'b0, 32'hA0};
        vecs[4]  = '{32'h10C, 0, -1, 1'b1, 32'hA3};
        vecs[5]  = '{32'h200, 0,  2, 1'b0, 32'hC0DE0200};
        vecs[6]  = '{32'h200, 0, -1, 1'b0, 32'hC0DE0200};
        vecs[7]  = '{32'h104, 5, -1, 1'b0, 32'hA1};
        vecs[8]  = '{32'h107, 0,  4, 1'b1, 32'hA1};
        vecs[9]  = '{32'h100, 0, -1, 1'b0, 32'hA0};
        vecs[10] = '{32'h20C, 0, -1, 1'b0, 32'hC0DE020C};

        model_clear();
        #3;
        check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++)
            fetch(vecs[i].addr, vecs[i].dly, vecs[i].fl, vecs[i].exp_hit, vecs[i].exp_data);

        // rdy low during a hit lookup delays the response without losing it
        start_req(32'h208);
        rdy = 1'b0;
        #1;
        check("frozen_resp_valid", resp_valid, 0);
        check("frozen_req_ready", req_ready, 0);
        @(negedge clk);
        check("frozen_resp_valid2", resp_valid, 0);
        rdy = 1'b1;
        #1;
        check("thawed_resp_valid", resp_valid, 1);
        check("thawed_resp_data", resp_data, 32'hC0DE0208);
        @(negedge clk);
        check("thawed_pulse_end", resp_valid, 0);

        // reset in the middle of a refill
        start_req(32'h700);
        @(negedge clk);
        check("rst_seq_mem_req", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_word(32'h700 + 32'(4 * b));
            @(negedge clk);
        end
        mem_resp_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_zero("midrefill_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        fetch(32'h700, 0, -1, 1'b0, mem_word(32'h700));
        fetch(32'h704, 0, -1, 1'b1, mem_word(32'h704));

        for (int i = 0; i < 40; i++) begin
            a  = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4)
               | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            fl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
            eh = mv[a[9:4]] && (mt[a[9:4]] == a[31:10]);
            fetch(a, int'($urandom_range(0, 3)), fl, eh, mem_word({a[31:2], 2'b00}));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gelato_l1_icache.md
GELATO_L1_ICACHE -- requirements
Module: gelato_l1_icache

Interface
REQ-001 Parameter LINE_COUNT, default 64, number of direct-mapped lines (power of two).
REQ-002 Parameter LINE_WORDS, default 4, 32-bit words per line (power of two, >=2).
REQ-003 Parameter ADDR_WIDTH, default 32, byte-address width; DATA_WIDTH fixed at 32.
REQ-004 One clock and one reset: clk is the single clock; rst_n is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 rdy  input  1  global enable; low freezes all state and outputs.
REQ-008 req_valid  input  1  fetch requests an instruction word.
REQ-009 req_addr  input  ADDR_WIDTH  byte address of the requested word; bits [1:0] ignored.
REQ-010 req_ready  output  1  cache accepts the request this cycle.
REQ-011 resp_valid  output  1  one-cycle pulse: resp_data is valid.
REQ-012 resp_data  output  32  instruction word.
REQ-013 resp_addr  output  ADDR_WIDTH  echo of the accepted req_addr.
REQ-014 flush  input  1  invalidate every line.
REQ-015 mem_req_valid  output  1  line refill request to the next level.
REQ-016 mem_req_addr  output  ADDR_WIDTH  line-aligned refill address.
REQ-017 mem_req_ready  input  1  next level accepts the refill request.
REQ-018 mem_resp_valid  input  1  one refill beat present.
REQ-019 mem_resp_data  input  32  refill word; beats arrive in ascending word order, offset 0 first.

Function
REQ-020 Address split: word = [log2(LINE_WORDS)+1:2], index = next log2(LINE_COUNT) bits, tag = remaining upper bits.
REQ-021 FSM states: IDLE, LOOKUP, MISS_REQ, REFILL, RESPOND.
REQ-022 req_ready is 1 only in IDLE with rdy high; a handshake happens when req_valid && req_ready, and the address is latched.
REQ-023 IDLE -> LOOKUP on handshake; on any other cycle the FSM stays in IDLE.
REQ-024 LOOKUP, hit (valid && tag match): resp_valid=1, resp_data from the array; next state IDLE. Hit latency: resp_valid is asserted in the cycle after the handshake.
REQ-025 LOOKUP, miss: next state MISS_REQ; mem_req_valid=1 with mem_req_addr = latched address with word and byte bits zeroed.
REQ-026 MISS_REQ holds mem_req_valid and mem_req_addr stable until mem_req_ready=1, then drops mem_req_valid and goes to REFILL.
REQ-027 REFILL writes each mem_resp_valid beat into the indexed line at a beat counter (0..LINE_WORDS-1) that wraps to 0.
REQ-028 On the last beat, REFILL writes the tag, sets the valid bit, and goes to RESPOND.
REQ-029 RESPOND: resp_valid=1 with the requested word of the refilled line, then IDLE. Miss latency = 2 + handshake wait + beat cycles.
REQ-030 resp_valid is never asserted outside LOOKUP-hit or RESPOND; there is no response backpressure.
REQ-031 flush in any state clears all valid bits in that cycle.
REQ-032 flush during MISS_REQ/REFILL: the refill completes and the response is delivered, but the line's valid bit is not set.
REQ-033 flush simultaneous with a LOOKUP: the lookup result uses the pre-flush valid bits.
REQ-034 mem_resp_valid outside REFILL is ignored.
REQ-035 rdy low: no state change, no counter advance, and no array write; a mem beat arriving while rdy is low is lost (the next level must not send beats while rdy is low).

Reset
REQ-036 rst_n low: FSM=IDLE, beat counter=0, all valid bits=0, req_ready=0, resp_valid=0, resp_data=0, resp_addr=0, mem_req_valid=0, mem_req_addr=0.
REQ-037 Tag and data arrays are not reset.
REQ-038 Reset mid-refill abandons the refill immediately; mem_req_valid deasserts asynchronously.

Structure
REQ-039 Package gelato_cache_pkg holds the FSM state enum, the default LINE_COUNT and LINE_WORDS, and the address-field width localparams.
REQ-040 Sub-module gelato_l1_icache_array holds storage: valid bits with reset and flush, tags, and data words; it has one read port and one word-write port.

Verification
REQ-041 Cold request at 0x100 -> MISS_REQ with mem_req_addr=0x100; feed beats 0xA0..0xA3 -> resp_data=0xA0, resp_addr=0x100.
REQ-042 Repeat request at 0x108 -> hit; resp_valid in the cycle after the handshake with data 0xA2; no mem_req_valid.
REQ-043 Request at 0x500 (same index as 0x100, different tag) -> miss and refill; a following request at 0x100 misses again.
REQ-044 flush asserted during beat 2 of a refill -> the response is still delivered; an immediate re-request of the same address misses.
REQ-045 mem_req_ready held low for 5 cycles -> mem_req_valid and mem_req_addr are stable throughout; the refill proceeds after ready rises.
REQ-046 rst_n pulsed low during REFILL -> all outputs are 0 asynchronously; the first request after reset misses.
